// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter owning the 5-entry PWM/output-enable register bank
// Ports:
//   clk, rst                      clock, async active-high reset
//   s_valid/s_ready/s_addr/s_data SPI decoder write channel (ready is a combinational grant)
//   h_valid/h_ready/h_addr/h_data local requester write channel (ready is a combinational grant)
//   pwm_period_end                1-cycle pulse on the last clk of each PWM period
//   en_reg_out_7_0..en_reg_pwm_15_8  registers at addresses 0x00..0x03
//   pwm_duty_cycle                active duty value (address 0x04)
//   duty_pending                  a deferred duty value waits for the next period boundary
//   wr_err                        1-cycle pulse after an accepted write to an unmapped address
module reg_write_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int DUTY_DEFER = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_data,
    input  logic              h_valid,
    output logic              h_ready,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_data,
    input  logic              pwm_period_end,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              duty_pending,
    output logic              wr_err
);
    logic              last_grant_q;
    logic [DATA_W-1:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q, shadow_q;
    logic              pending_q, wr_err_q;
    logic              hs, wr_duty;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // last_grant_q: 1 = H was served last, so S wins the next contention
    assign s_ready  = s_valid & (~h_valid | last_grant_q);
    assign h_ready  = h_valid & (~s_valid | ~last_grant_q);
    assign hs       = s_ready | h_ready;
    assign sel_addr = s_ready ? s_addr : h_addr;
    assign sel_data = s_ready ? s_data : h_data;
    assign wr_duty  = hs && sel_addr == ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            out_lo_q     <= '0;
            out_hi_q     <= '0;
            pwm_lo_q     <= '0;
            pwm_hi_q     <= '0;
            duty_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            wr_err_q <= hs && sel_addr > ADDR_W'(4);
            if (hs) last_grant_q <= h_ready;
            if (hs && sel_addr == ADDR_W'(0)) out_lo_q <= sel_data;
            if (hs && sel_addr == ADDR_W'(1)) out_hi_q <= sel_data;
            if (hs && sel_addr == ADDR_W'(2)) pwm_lo_q <= sel_data;
            if (hs && sel_addr == ADDR_W'(3)) pwm_hi_q <= sel_data;
            if (DUTY_DEFER == 0) begin
                if (wr_duty) duty_q <= sel_data;
            end else if (wr_duty) begin
                // a write landing on the boundary bypasses the shadow and drops any older value
                if (pwm_period_end) begin
                    duty_q    <= sel_data;
                    pending_q <= 1'b0;
                end else begin
                    shadow_q  <= sel_data;
                    pending_q <= 1'b1;
                end
            end else if (pwm_period_end && pending_q) begin
                duty_q    <= shadow_q;
                pending_q <= 1'b0;
            end
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign duty_pending    = pending_q;
    assign wr_err          = wr_err_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0, h_valid = 1'b0, pwm_period_end = 1'b0;
    logic [6:0] s_addr = '0, h_addr = '0;
    logic [7:0] s_data = '0, h_data = '0;
    logic       s_ready, h_ready, duty_pending, wr_err;
    logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
    int         total = 0;
    int         bad = 0;

    reg_write_arbiter dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
        .h_valid(h_valid), .h_ready(h_ready), .h_addr(h_addr), .h_data(h_data),
        .pwm_period_end(pwm_period_end),
        .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
        .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
        .pwm_duty_cycle(duty), .duty_pending(duty_pending), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        h_valid = 1'b0;
        pwm_period_end = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        // 1: reset state, then a write interrupted by reset
        chk("rst_duty", duty, 8'h00);
        chk("rst_pending", {7'b0, duty_pending}, 8'h00);
        s_valid = 1'b1; s_addr = 7'h00; s_data = 8'h11;
        step();
        chk("pre_rst_out_lo", out_lo, 8'h11);
        s_addr = 7'h02; s_data = 8'hAA;
        #2 rst = 1'b1;
        step();
        chk("rst_out_lo", out_lo, 8'h00);
        chk("rst_pwm_lo", pwm_lo, 8'h00);
        chk("rst_pending2", {7'b0, duty_pending}, 8'h00);
        chk("rst_wr_err", {7'b0, wr_err}, 8'h00);
        idle();
        rst = 1'b0;
        step();
        chk("rst_hold_pwm_lo", pwm_lo, 8'h00);
        chk("idle_ready", {6'b0, s_ready, h_ready}, 8'h00);
        // 2: single writes
        s_valid = 1'b1; s_addr = 7'h00; s_data = 8'h5A;
        #1 chk("s_single_ready", {6'b0, s_ready, h_ready}, 8'h02);
        chk("s_latency", out_lo, 8'h00);
        step();
        chk("s_out_lo", out_lo, 8'h5A);
        s_valid = 1'b0;
        h_valid = 1'b1; h_addr = 7'h03; h_data = 8'hC3;
        #1 chk("h_single_ready", {6'b0, s_ready, h_ready}, 8'h01);
        step();
        chk("h_pwm_hi", pwm_hi, 8'hC3);
        // 3: contention, last grant was H so S goes first
        s_valid = 1'b1; s_addr = 7'h00; s_data = 8'h01;
        h_valid = 1'b1; h_addr = 7'h01; h_data = 8'hA1;
        #1 chk("cont1_grant", {6'b0, s_ready, h_ready}, 8'h02);
        step();
        chk("cont1_out_lo", out_lo, 8'h01);
        chk("cont1_out_hi", out_hi, 8'h00);
        s_data = 8'h02;
        #1 chk("cont2_grant", {6'b0, s_ready, h_ready}, 8'h01);
        step();
        chk("cont2_out_hi", out_hi, 8'hA1);
        chk("cont2_out_lo", out_lo, 8'h01);
        h_data = 8'hA2;
        #1 chk("cont3_grant", {6'b0, s_ready, h_ready}, 8'h02);
        step();
        chk("cont3_out_lo", out_lo, 8'h02);
        s_data = 8'h03;
        #1 chk("cont4_grant", {6'b0, s_ready, h_ready}, 8'h01);
        step();
        chk("cont4_out_hi", out_hi, 8'hA2);
        chk("cont4_out_lo", out_lo, 8'h02);
        idle();
        // 4: deferred duty update
        s_valid = 1'b1; s_addr = 7'h04; s_data = 8'h80;
        step();
        chk("defer1_pending", {7'b0, duty_pending}, 8'h01);
        chk("defer1_duty", duty, 8'h00);
        s_data = 8'h40;
        step();
        chk("defer2_pending", {7'b0, duty_pending}, 8'h01);
        chk("defer2_duty", duty, 8'h00);
        idle();
        step();
        chk("defer_wait_duty", duty, 8'h00);
        pwm_period_end = 1'b1;
        step();
        chk("boundary_duty", duty, 8'h40);
        chk("boundary_pending", {7'b0, duty_pending}, 8'h00);
        step();
        chk("boundary_nopend_duty", duty, 8'h40);
        // 5: bypass with an older shadow pending
        pwm_period_end = 1'b0;
        s_valid = 1'b1; s_data = 8'h77;
        step();
        chk("bypass_pre_pending", {7'b0, duty_pending}, 8'h01);
        s_data = 8'h10;
        pwm_period_end = 1'b1;
        step();
        chk("bypass_duty", duty, 8'h10);
        chk("bypass_pending", {7'b0, duty_pending}, 8'h00);
        s_valid = 1'b0;
        step();
        chk("bypass_discard", duty, 8'h10);
        idle();
        // 6: unmapped addresses
        h_valid = 1'b1; h_addr = 7'h7F; h_data = 8'hFF;
        #1 chk("bad_ready", {6'b0, s_ready, h_ready}, 8'h01);
        step();
        chk("bad_wr_err", {7'b0, wr_err}, 8'h01);
        chk("bad_out_lo", out_lo, 8'h02);
        chk("bad_out_hi", out_hi, 8'hA2);
        chk("bad_pwm_lo", pwm_lo, 8'h00);
        chk("bad_pwm_hi", pwm_hi, 8'hC3);
        chk("bad_duty", duty, 8'h10);
        h_valid = 1'b0;
        step();
        chk("bad_wr_err_clear", {7'b0, wr_err}, 8'h00);
        h_valid = 1'b1; h_addr = 7'h44; h_data = 8'h99;
        step();
        chk("alias_wr_err", {7'b0, wr_err}, 8'h01);
        chk("alias_duty", duty, 8'h10);
        chk("alias_pending", {7'b0, duty_pending}, 8'h00);
        h_addr = 7'h05;
        step();
        chk("addr5_wr_err", {7'b0, wr_err}, 8'h01);
        idle();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
